uart_txrx: RTL and testbench

- Full-duplex 8N1 UART: transmitter (uart_tx function) and receiver (uart_rx function) in one block, with a shared baud timing parameter.
- Sits between the parallel byte interface of a host and the serial pins.
- For loopback test, tx is tied externally to rx; a byte sent through start_tx/data_in must reappear on data_out with an rx_done pulse.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_rx_core.sv | 123 ++++++++++++
 rtl/uart_tx_core.sv | 106 ++++++++++
 rtl/uart_txrx.sv | 47 ++++
 tb/tb_uart_txrx.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_txrx transmitter/receiver pair.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int DATA_BITS = 8;
  localparam int IDX_W     = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 serial receiver: synchronizes rx, samples mid-bit, rejects start glitches and bad stop bits.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]    C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(DATA_BITS - 1);

  logic                 r_sync1, r_sync2;
  logic                 w_rx;
  uart_state_t          r_state, w_state_next;
  logic [CW-1:0]        r_cnt, w_cnt_next;
  logic [IDX_W-1:0]     r_idx, w_idx_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic [DATA_BITS-1:0] r_data, w_data_next;
  logic                 r_done, w_done_next;
  logic                 r_ferr, w_ferr_next;
  logic                 w_bit_end;

  assign w_rx      = r_sync2;
  assign w_bit_end = (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_data  <= w_data_next;
      r_done  <= w_done_next;
      r_ferr  <= w_ferr_next;
    end
  end

  // START ends at mid-bit, so every later full-bit count lands at a bit centre.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_data_next  = r_data;
    w_done_next  = 1'b0;
    w_ferr_next  = r_ferr;
    case (r_state)
      IDLE: begin
        if (!w_rx) begin
          w_state_next = START;
          w_cnt_next   = '0;
        end
      end
      START: begin
        if (r_cnt == C_HALF) begin
          w_cnt_next   = '0;
          w_idx_next   = '0;
          w_state_next = w_rx ? IDLE : DATA;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cnt_next   = '0;
          w_shift_next = {w_rx, r_shift[DATA_BITS-1:1]};
          if (r_idx == I_LAST) begin
            w_state_next = STOP;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      STOP: begin
        if (r_ferr) begin
          // Framing error: hold here until the line returns to idle.
          if (w_rx) begin
            w_state_next = IDLE;
            w_ferr_next  = 1'b0;
            w_cnt_next   = '0;
          end
        end else if (w_bit_end) begin
          w_cnt_next = '0;
          if (w_rx) begin
            w_state_next = IDLE;
            w_data_next  = r_shift;
            w_done_next  = 1'b1;
          end else begin
            w_ferr_next = 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign data_out = r_data;
  assign rx_done  = r_done;

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 serial transmitter: frames one byte per accepted start_tx, LSB first.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_tx,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]    C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(DATA_BITS - 1);

  uart_state_t          r_state, w_state_next;
  logic [CW-1:0]        r_cnt, w_cnt_next;
  logic [IDX_W-1:0]     r_idx, w_idx_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic                 r_tx, w_tx_next;
  logic                 r_busy, w_busy_next;
  logic                 w_bit_end;

  assign w_bit_end = (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
      r_busy  <= w_busy_next;
    end
  end

  // tx is registered, so each line level is decided one cycle ahead of its bit period.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    w_busy_next  = r_busy;
    case (r_state)
      IDLE: begin
        if (start_tx) begin
          w_state_next = START;
          w_shift_next = data_in;
          w_cnt_next   = '0;
          w_tx_next    = 1'b0;
          w_busy_next  = 1'b1;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_next = DATA;
          w_cnt_next   = '0;
          w_idx_next   = '0;
          w_tx_next    = r_shift[0];
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cnt_next = '0;
          if (r_idx == I_LAST) begin
            w_state_next = STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_idx_next   = r_idx + 1'b1;
            w_shift_next = r_shift >> 1;
            w_tx_next    = r_shift[1];
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
          w_busy_next  = 1'b0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign tx   = r_tx;
  assign busy = r_busy;

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing one bit timing.
module uart_txrx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_tx,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 busy,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_done
);

  logic                 w_tx, w_busy, w_rx_done;
  logic [DATA_BITS-1:0] w_data_out;

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk     (clk),
    .reset   (reset),
    .start_tx(start_tx),
    .data_in (data_in),
    .tx      (w_tx),
    .busy    (w_busy)
  );

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .data_out(w_data_out),
    .rx_done (w_rx_done)
  );

  assign tx       = w_tx;
  assign busy     = w_busy;
  assign data_out = w_data_out;
  assign rx_done  = w_rx_done;

endmodule

// File: tb/tb_uart_txrx.sv
// Directed and random loopback / direct-drive bench for uart_txrx at 16 clocks per bit.
module tb_uart_txrx;

  localparam int CPB = 16;

  logic       clk;
  logic       reset;
  logic       start_tx;
  logic [7:0] data_in;
  logic       tx;
  logic       busy;
  logic       rx;
  logic [7:0] data_out;
  logic       rx_done;

  logic       loop_en;
  logic       rx_drv;

  int checks = 0;
  int errors = 0;

  // Monitor-owned logs, read-only from the stimulus process.
  logic [7:0] rx_log[$];
  int         busy_total = 0;

  int         rx_rd = 0;
  logic [7:0] last_good = 8'h00;

  assign rx = loop_en ? tx : rx_drv;

  uart_txrx #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset   (reset),
    .start_tx(start_tx),
    .data_in (data_in),
    .tx      (tx),
    .busy    (busy),
    .rx      (rx),
    .data_out(data_out),
    .rx_done (rx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done) rx_log.push_back(data_out);
    if (busy) busy_total++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) check("busy_timeout", busy, 0);
  endtask

  // Reference frame: bit 0 start(0), bits 1..8 data LSB first, bit 9 stop(1).
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit interfere);
    int busy_start;
    wait_idle();
    busy_start = busy_total;
    start_tx = 1'b1;
    data_in  = b;
    tick();
    start_tx = 1'b0;
    data_in  = 8'($urandom);
    for (int k = 0; k < 10; k++) begin
      repeat (CPB / 2) tick();
      check($sformatf("tx_%02h_bit%0d", b, k), tx, frame_bit(b, k));
      if (interfere && k == 3) begin
        start_tx = 1'b1;
        data_in  = 8'h3C;
        tick();
        start_tx = 1'b0;
        repeat (CPB / 2 - 1) tick();
      end else begin
        repeat (CPB / 2) tick();
      end
    end
    check($sformatf("busy_len_%02h", b), busy_total - busy_start, 10 * CPB);
    check($sformatf("busy_clear_%02h", b), busy, 0);
  endtask

  task automatic expect_rx(input logic [7:0] b);
    check($sformatf("rx_avail_%02h", b), rx_log.size() > rx_rd, 1);
    if (rx_log.size() > rx_rd) begin
      check($sformatf("rx_data_%02h", b), rx_log[rx_rd], b);
      rx_rd++;
    end
    last_good = b;
    $display("rx expected %02h data_out %02h", b, data_out);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    for (int k = 0; k < 10; k++) begin
      rx_drv = (k == 9) ? stop_bit : frame_bit(b, k);
      repeat (CPB) tick();
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    logic [7:0] seq [4];
    logic [7:0] rnd [4];
    seq = '{8'h00, 8'hFF, 8'h01, 8'h80};

    reset = 1'b1; start_tx = 1'b0; data_in = 8'h00; loop_en = 1'b1; rx_drv = 1'b1;
    repeat (4) tick();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_rx_done", rx_done, 0);
    reset = 1'b0;
    tick();

    // Basic loopback
    send_byte(8'hA5, 1'b0);
    expect_rx(8'hA5);
    check("data_out_A5", data_out, 8'hA5);

    // Back-to-back boundary bytes
    for (int i = 0; i < 4; i++) send_byte(seq[i], 1'b0);
    for (int i = 0; i < 4; i++) expect_rx(seq[i]);

    // start_tx while busy is ignored
    send_byte(8'hA5, 1'b1);
    expect_rx(8'hA5);
    repeat (3 * CPB) tick();
    check("ignored_no_extra", rx_log.size(), rx_rd);
    check("ignored_not_busy", busy, 0);

    // Random bytes
    for (int i = 0; i < 4; i++) rnd[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) send_byte(rnd[i], 1'b0);
    for (int i = 0; i < 4; i++) expect_rx(rnd[i]);

    // Framing error, then a good frame
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (4) tick();
    drive_frame(8'h5A, 1'b0);
    repeat (30) tick();
    check("ferr_no_done", rx_log.size(), rx_rd);
    check("ferr_data_hold", data_out, last_good);
    drive_frame(8'hC3, 1'b1);
    repeat (10) tick();
    expect_rx(8'hC3);

    // Short glitch while idle
    rx_drv = 1'b0;
    repeat (4) tick();
    rx_drv = 1'b1;
    repeat (3 * CPB) tick();
    check("glitch_no_done", rx_log.size(), rx_rd);
    check("glitch_data_hold", data_out, last_good);

    // Reset mid-frame
    loop_en = 1'b1;
    wait_idle();
    start_tx = 1'b1;
    data_in  = 8'h69;
    tick();
    start_tx = 1'b0;
    repeat (49) tick();
    check("mid_tx_low_or_bit", busy, 1);
    reset = 1'b1;
    tick();
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_data_out", data_out, 8'h00);
    reset = 1'b0;
    repeat (12 * CPB) tick();
    check("midrst_no_done", rx_log.size(), rx_rd);
    send_byte(8'h96, 1'b0);
    expect_rx(8'h96);
    repeat (2 * CPB) tick();
    check("final_no_extra", rx_log.size(), rx_rd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
